// File: rtl/sequence_player.sv
// sequence_player: stores the colour sequence and plays it on the LEDs.
// Owns all display timing: speed-dependent on-time, fixed dark gap.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           sync: empty sequence, abort playback
//   append_valid    append request, append_color = colour (2 bits)
//   append_ready    append accepted when valid & ready
//   play_start      start playback of entries 0..seq_len-1
//   speed_fast      1 = CLK_FREQ on-time, 0 = 2*CLK_FREQ
//   busy            not idle
//   done            1-cycle pulse when playback finishes
//   leds_out        one-hot colour display
//   seq_len, full   stored entry count, count == MAX_LEN
//   rd_idx          readback index
//   rd_color        mem[rd_idx], 2'b00 beyond seq_len
module sequence_player #(
  parameter int CLK_FREQ   = 200_000_000,
  parameter int MAX_LEN    = 32,
  parameter int GAP_CYCLES = 50_000_000,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          append_valid,
  input  logic [1:0]    append_color,
  output logic          append_ready,
  input  logic          play_start,
  input  logic          speed_fast,
  output logic          busy,
  output logic          done,
  output logic [3:0]    leds_out,
  output logic [LW-1:0] seq_len,
  output logic          full,
  input  logic [IW-1:0] rd_idx,
  output logic [1:0]    rd_color
);

  // Timer must hold the longest on-time and the gap.
  localparam int SLOW = 2 * CLK_FREQ;
  localparam int TSPAN =
    (SLOW > GAP_CYCLES) ? SLOW : GAP_CYCLES;
  localparam int TW = (TSPAN > 1) ? $clog2(TSPAN) : 1;

  localparam logic [TW-1:0] FAST_LAST =
    TW'(CLK_FREQ - 1);
  localparam logic [TW-1:0] SLOW_LAST =
    TW'(SLOW - 1);
  localparam logic [TW-1:0] GAP_LAST =
    TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LED_ON,
    LED_GAP,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    mem [MAX_LEN];
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;

  logic on_last;
  logic gap_last;
  logic idx_last;
  logic append_fire;

  function automatic logic [3:0] color_map(
    input logic [1:0] c
  );
    return 4'b0001 << c;
  endfunction

  assign full = (seq_len == LW'(MAX_LEN));

  assign append_ready = (state == IDLE)
                      & ~full
                      & ~clear
                      & ~play_start;

  assign append_fire = append_valid & append_ready;

  // rd_idx may point past the stored entries; mask them.
  assign rd_color = (LW'(rd_idx) < seq_len)
                  ? mem[rd_idx]
                  : 2'b00;

  // >= rather than == so a slow->fast switch late in a
  // colour still ends it instead of running the timer on.
  assign on_last = speed_fast
                 ? (timer >= FAST_LAST)
                 : (timer >= SLOW_LAST);

  assign gap_last = (timer >= GAP_LAST);

  assign idx_last = (LW'(idx) == seq_len - LW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      seq_len  <= '0;
      idx      <= '0;
      timer    <= '0;
      leds_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mem[i] <= 2'b00;
      end
    end else begin
      done <= 1'b0;
      if (clear) begin
        // Stale mem contents are hidden by seq_len.
        state    <= IDLE;
        seq_len  <= '0;
        idx      <= '0;
        timer    <= '0;
        leds_out <= '0;
        busy     <= 1'b0;
      end else begin
        if (append_fire) begin
          mem[seq_len[IW-1:0]] <= append_color;
          seq_len <= seq_len + LW'(1);
        end
        unique case (state)
          IDLE: begin
            if (play_start) begin
              busy <= 1'b1;
              if (seq_len != '0) begin
                state    <= LED_ON;
                idx      <= '0;
                timer    <= '0;
                leds_out <= color_map(mem[0]);
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          LED_ON: begin
            if (on_last) begin
              state    <= LED_GAP;
              timer    <= '0;
              leds_out <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          LED_GAP: begin
            if (gap_last) begin
              timer <= '0;
              if (idx_last) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= LED_ON;
                idx      <= idx + IW'(1);
                leds_out <=
                  color_map(mem[idx + IW'(1)]);
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          DONE: begin
            state    <= IDLE;
            busy     <= 1'b0;
            leds_out <= '0;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            leds_out <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed checks of sequence_player
// with CLK_FREQ=4, GAP_CYCLES=2, MAX_LEN=4.
module tb_sequence_player;

  localparam int CF = 4;
  localparam int GP = 2;
  localparam int ML = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       append_valid = 1'b0;
  logic [1:0] append_color = 2'b00;
  logic       append_ready;
  logic       play_start = 1'b0;
  logic       speed_fast = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] leds_out;
  logic [2:0] seq_len;
  logic       full;
  logic [1:0] rd_idx = 2'b00;
  logic [1:0] rd_color;

  int n_run = 0;
  int n_fail = 0;

  sequence_player #(
    .CLK_FREQ  (CF),
    .MAX_LEN   (ML),
    .GAP_CYCLES(GP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .append_valid(append_valid),
    .append_color(append_color),
    .append_ready(append_ready),
    .play_start  (play_start),
    .speed_fast  (speed_fast),
    .busy        (busy),
    .done        (done),
    .leds_out    (leds_out),
    .seq_len     (seq_len),
    .full        (full),
    .rd_idx      (rd_idx),
    .rd_color    (rd_color)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] c);
    append_valid = 1'b1;
    append_color = c;
    tick();
    append_valid = 1'b0;
  endtask

  // Plays the 10,00,11 sequence fast; poke pulses
  // play_start and an append in each gap.
  task automatic play_fast(input bit poke);
    logic [3:0] col;
    speed_fast = 1'b1;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      col = (k == 0) ? 4'b0100 :
            (k == 1) ? 4'b0001 : 4'b1000;
      for (int j = 0; j < CF; j++) begin
        chk($sformatf("on%0d_%0d", k, j),
            32'({busy, done, leds_out}),
            32'({2'b10, col}));
        tick();
      end
      for (int j = 0; j < GP; j++) begin
        chk($sformatf("gap%0d_%0d", k, j),
            32'({busy, done, leds_out}),
            32'(6'b100000));
        if (poke && j == 0) begin
          play_start   = 1'b1;
          append_valid = 1'b1;
          append_color = 2'b01;
        end
        tick();
        play_start   = 1'b0;
        append_valid = 1'b0;
      end
    end
    chk("done_pulse", 32'({busy, done, leds_out}),
        32'(6'b110000));
    tick();
    chk("after_done", 32'({busy, done, leds_out}),
        32'(6'b000000));
  endtask

  initial begin
    int cnt;

    // 1: reset
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_leds", 32'(leds_out), 32'(4'b0000));
    chk("rst_len", 32'(seq_len), 32'(0));
    chk("rst_flags",
        32'({busy, done, append_ready, full}),
        32'(4'b0010));

    // 2: three colours, fast
    push(2'b10);
    push(2'b00);
    push(2'b11);
    chk("len3", 32'(seq_len), 32'(3));
    play_fast(1'b0);
    rd_idx = 2'd2;
    #1;
    chk("rd2", 32'(rd_color), 32'(2'b11));
    rd_idx = 2'd3;
    #1;
    chk("rd3_masked", 32'(rd_color), 32'(2'b00));

    // 6: pokes during gaps are ignored
    play_fast(1'b1);
    chk("len_after_poke", 32'(seq_len), 32'(3));

    // 3: empty sequence
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cleared", 32'(seq_len), 32'(0));
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("empty_done", 32'({busy, done, leds_out}),
        32'(6'b110000));
    tick();
    chk("empty_idle", 32'({busy, done, leds_out}),
        32'(6'b000000));

    // 4: fill to capacity, fifth dropped
    push(2'b01);
    push(2'b10);
    push(2'b00);
    push(2'b11);
    chk("full_flags", 32'({full, append_ready}),
        32'(2'b10));
    push(2'b01);
    chk("len_cap", 32'(seq_len), 32'(4));
    rd_idx = 2'd3;
    #1;
    chk("rd_4th", 32'(rd_color), 32'(2'b11));
    rd_idx = 2'd0;
    #1;
    chk("rd_1st", 32'(rd_color), 32'(2'b01));

    // 5: clear in third slow LED_ON cycle
    speed_fast = 1'b0;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("slow_on1", 32'(leds_out), 32'(4'b0010));
    tick();
    tick();
    chk("slow_on3", 32'(leds_out), 32'(4'b0010));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_out", 32'({busy, done, leds_out}),
        32'(6'b000000));
    chk("clr_len", 32'(seq_len), 32'(0));
    for (int i = 0; i < ML; i++) begin
      rd_idx = 2'(i);
      #1;
      chk($sformatf("clr_rd%0d", i),
          32'(rd_color), 32'(2'b00));
    end
    tick();
    chk("clr_nodone", 32'(done), 32'(0));

    // slow on-time is 2*CLK_FREQ cycles
    push(2'b10);
    speed_fast = 1'b0;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    cnt = 0;
    while (leds_out == 4'b0100 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("slow_len", 32'(cnt), 32'(2 * CF));
    chk("slow_gap0", 32'({busy, done, leds_out}),
        32'(6'b100000));
    tick();
    chk("slow_gap1", 32'({busy, done, leds_out}),
        32'(6'b100000));
    tick();
    chk("slow_done", 32'({busy, done, leds_out}),
        32'(6'b110000));
    tick();

    // async reset mid-playback
    push(2'b11);
    speed_fast = 1'b1;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    tick();
    chk("pre_rst", 32'(leds_out), 32'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        32'({busy, done, leds_out, seq_len}),
        32'(9'd0));
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst", 32'({append_ready, full}),
        32'(2'b10));

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
